sp_ram_arbiter: RTL and testbench
=================================

# sp_ram_arbiter

Two-requester round-robin arbiter and sequencer for one `single_port_RAM` instance. It grants at most one access per cycle and drives the RAM's `din`/`addr`/`wr_en`. It tracks each read through the RAM's two-cycle pipeline and returns the data to the requester that issued it. It sits between two client engines (e.g. FIFO write side and read side) and a shared bank, so one single-port RAM serves both.

## Interface
- `DATA_WIDTH`, default 8: data width; must match the RAM.
- `RAM_DEPTH`, default 256: RAM entries.
- `LB_RAM_DEPTH`, default `$clog2(RAM_DEPTH)`: address width.

Ports (X ∈ {a, b}, one identical set per requester):
- `clk`  in  1  clock; every register in the block is clocked on its rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `X_req_valid`  in  1  requester X has an access pending.
- `X_req_ready`  out  1  access accepted this cycle. A transfer occurs when valid & ready.
- `X_req_wr`  in  1  1 = write, 0 = read.
- `X_req_addr`  in  LB_RAM_DEPTH  access address.
- `X_req_din`  in  DATA_WIDTH  write data; ignored for reads.
- `X_rsp_valid`  out  1  one-cycle pulse: read data for X is present. No backpressure.
- `X_rsp_dout`  out  DATA_WIDTH  read data. Valid only while `X_rsp_valid` is high; otherwise it holds its last value.
- `ram_din`  out  DATA_WIDTH  to RAM `din`.
- `ram_addr`  out  LB_RAM_DEPTH  to RAM `addr`.
- `ram_wr_en`  out  1  to RAM `wr_en`.
- `ram_dout`  in  DATA_WIDTH  from RAM `dout`.

## Operation
**Arbitration (combinational, every cycle)**
- If only one requester is valid, it is granted.
- If both are valid, the requester indicated by the priority pointer `prio` is granted (0 = a, 1 = b).
- After any transfer, `prio` moves to the requester that was not granted. It is unchanged in cycles with no transfer.
- `X_req_ready` equals the grant to X. Ready may depend on valid; requesters must not make valid depend on ready.
- At most one ready is high per cycle.

**RAM drive**
- The granted request's addr/din/wr go to the `ram_*` ports.
- When nothing is granted: `ram_wr_en` = 0, and `ram_addr`/`ram_din` hold their previous value. They are registered, not driven from request inputs, to avoid toggling.
- Holding `ram_addr` means the RAM's idle read is harmless.

**Response tracking**
- A 2-stage shift register carries {`live`, `id`} per grant. `live` = 1 for reads only, since writes produce no response.
- When stage 2 is live, `ram_dout` is latched into `X_rsp_dout` of the requester named by `id`, and that requester's `X_rsp_valid` pulses.
- The response pipeline cannot stall, so no response is ever dropped.

**Reset**
- During `rst`: both readys = 0, `ram_wr_en` = 0, the pipeline `live` bits are cleared, and `prio` = 0.
- After reset: `ram_addr` = 0, `ram_din` = 0, and both rsp_valid = 0.
- Reset mid-operation discards reads in flight; no response is issued for them.

## Timing
- **Handshake:** a transfer in cycle T puts the request on `ram_*` during T. The RAM samples it at the end of T.
- **Read latency:** `ram_dout` holds the data during T+2. `X_rsp_valid`/`X_rsp_dout` are high during T+2, driven combinationally from stage 2 and `ram_dout`.
- **Write:** the RAM array is updated at the end of T+1.
- **Write at T, read of the same address at T+1:** returns the new data.
- **Read and write of the same address in one cycle:** impossible, because there is one grant per cycle.
- **Throughput:** one access per cycle. Under continuous dual request, a and b alternate exactly.
- **Response overlap:** responses for a and b never fall in the same cycle.

## Structure
- Package `sp_ram_arb_pkg`:
  - `typedef enum logic {REQ_A, REQ_B} req_id_t`
  - tag struct `{logic live; req_id_t id;}`
  - `localparam RD_LATENCY = 2`
- Sub-module `rr_arbiter2`: two valids, owns the `prio` register, outputs a one-hot grant. It also receives `clk`, `rst` and a transfer-taken input.
- The RAM is instantiated by the parent, not inside this block.

## Test plan
- **Reset:** hold `rst` 3 cycles with both valids high, then release. Both readys stay 0 during reset; after release a wins first.
- **Single writer/reader:** a writes 0xA5 to addr 0x10 in cycle 5, then reads 0x10 in cycle 6. `a_rsp_valid` is high in cycle 8 with 0xA5; `b_rsp_valid` is never high.
- **Contention:** both valid for 6 cycles, all reads. Grants go a,b,a,b,a,b. Responses for each read arrive 2 cycles after its grant, tagged to the correct requester.
- **Mixed:** a writes 0x3C to addr 7 while b repeatedly reads addr 7. b's reads granted before a's write return the old value; reads granted after it return 0x3C.
- **Reset mid-read:** assert `rst` one cycle after a read grant. No `rsp_valid` follows, and `prio` returns to a.
- **Address wrap:** with default parameters, a writes addrs 0xFF and 0x00, then reads both. Each returns its own data, with no aliasing.

Source files
------------

// File: rtl/sp_ram_arb_pkg.sv
// Shared types for the single-port RAM arbiter: requester ids, the per-grant
// response tag, and the RAM read latency the tag pipeline must match.
package sp_ram_arb_pkg;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    live;
        req_id_t id;
    } rsp_tag_t;

    localparam int RD_LATENCY = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Owns the priority pointer; the grant is
// combinational from the valids, and the pointer advances only on a transfer.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic valid_a,
    input  logic valid_b,
    input  logic xfer,
    output logic grant_a,
    output logic grant_b
);

    logic prio_q;
    logic prio_d;

    // prio_q = 0 favours a on contention, 1 favours b.
    always_comb begin
        grant_a = valid_a & (~valid_b | ~prio_q);
        grant_b = valid_b & (~valid_a |  prio_q);
        prio_d  = prio_q;
        if (xfer) begin
            prio_d = grant_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Round-robin sharing of one single-port RAM between two requesters, with a
// tag pipeline that routes each read's data back to whoever issued it.
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int RAM_DEPTH    = 256,
    parameter int LB_RAM_DEPTH = $clog2(RAM_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    a_req_valid,
    output logic                    a_req_ready,
    input  logic                    a_req_wr,
    input  logic [LB_RAM_DEPTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0]   a_req_din,
    output logic                    a_rsp_valid,
    output logic [DATA_WIDTH-1:0]   a_rsp_dout,

    input  logic                    b_req_valid,
    output logic                    b_req_ready,
    input  logic                    b_req_wr,
    input  logic [LB_RAM_DEPTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0]   b_req_din,
    output logic                    b_rsp_valid,
    output logic [DATA_WIDTH-1:0]   b_rsp_dout,

    output logic [DATA_WIDTH-1:0]   ram_din,
    output logic [LB_RAM_DEPTH-1:0] ram_addr,
    output logic                    ram_wr_en,
    input  logic [DATA_WIDTH-1:0]   ram_dout
);

    logic arb_grant_a;
    logic arb_grant_b;
    logic gnt_a;
    logic gnt_b;
    logic xfer;

    logic [LB_RAM_DEPTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_din_q,  ram_din_d;

    rsp_tag_t [RD_LATENCY-1:0] pipe_q, pipe_d;
    rsp_tag_t                  tail;

    logic [DATA_WIDTH-1:0] a_dout_q, a_dout_d;
    logic [DATA_WIDTH-1:0] b_dout_q, b_dout_d;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid_a (a_req_valid),
        .valid_b (b_req_valid),
        .xfer    (xfer),
        .grant_a (arb_grant_a),
        .grant_b (arb_grant_b)
    );

    // No access is accepted while reset is held.
    assign gnt_a       = arb_grant_a & ~rst;
    assign gnt_b       = arb_grant_b & ~rst;
    assign xfer        = gnt_a | gnt_b;
    assign a_req_ready = gnt_a;
    assign b_req_ready = gnt_b;

    // Idle cycles replay the last address/data so the RAM bus does not toggle.
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_wr_en  = 1'b0;
        if (gnt_a) begin
            ram_addr_d = a_req_addr;
            ram_din_d  = a_req_din;
            ram_wr_en  = a_req_wr;
        end else if (gnt_b) begin
            ram_addr_d = b_req_addr;
            ram_din_d  = b_req_din;
            ram_wr_en  = b_req_wr;
        end
        ram_addr = ram_addr_d;
        ram_din  = ram_din_d;
    end

    always_comb begin
        pipe_d[0].live = xfer & ~ram_wr_en;
        pipe_d[0].id   = gnt_b ? REQ_B : REQ_A;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // The tail tag lines up with the cycle in which ram_dout carries its data.
    always_comb begin
        tail        = pipe_q[RD_LATENCY-1];
        a_rsp_valid = tail.live & (tail.id == REQ_A) & ~rst;
        b_rsp_valid = tail.live & (tail.id == REQ_B) & ~rst;
        a_dout_d    = a_rsp_valid ? ram_dout : a_dout_q;
        b_dout_d    = b_rsp_valid ? ram_dout : b_dout_q;
        a_rsp_dout  = a_dout_d;
        b_rsp_dout  = b_dout_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            pipe_q     <= '0;
            a_dout_q   <= '0;
            b_dout_q   <= '0;
        end else begin
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            pipe_q     <= pipe_d;
            a_dout_q   <= a_dout_d;
            b_dout_q   <= b_dout_d;
        end
    end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: a behavioural two-cycle RAM on the ram_* bus and a
// transaction-level model (memory array + timed response queue) of the arbiter.
module tb_sp_ram_arbiter;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          a_req_valid, a_req_ready, a_req_wr, a_rsp_valid;
    logic [AW-1:0] a_req_addr;
    logic [DW-1:0] a_req_din, a_rsp_dout;
    logic          b_req_valid, b_req_ready, b_req_wr, b_rsp_valid;
    logic [AW-1:0] b_req_addr;
    logic [DW-1:0] b_req_din, b_rsp_dout;
    logic [DW-1:0] ram_din, ram_dout;
    logic [AW-1:0] ram_addr;
    logic          ram_wr_en;

    sp_ram_arbiter #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_wr(a_req_wr),
        .a_req_addr(a_req_addr), .a_req_din(a_req_din),
        .a_rsp_valid(a_rsp_valid), .a_rsp_dout(a_rsp_dout),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_wr(b_req_wr),
        .b_req_addr(b_req_addr), .b_req_din(b_req_din),
        .b_rsp_valid(b_rsp_valid), .b_rsp_dout(b_rsp_dout),
        .ram_din(ram_din), .ram_addr(ram_addr), .ram_wr_en(ram_wr_en), .ram_dout(ram_dout)
    );

    // Single-port RAM: inputs registered, array written one cycle later, read data one after that.
    logic [DW-1:0] ram_mem [DEPTH] = '{default: '0};
    logic [AW-1:0] ram_addr_r = '0;
    logic [DW-1:0] ram_din_r  = '0;
    logic          ram_we_r   = 1'b0;
    always @(posedge clk) begin
        ram_addr_r <= ram_addr;
        ram_din_r  <= ram_din;
        ram_we_r   <= ram_wr_en;
        if (ram_we_r) ram_mem[ram_addr_r] <= ram_din_r;
        ram_dout <= ram_mem[ram_addr_r];
    end

    // Reference model state.
    typedef struct {
        int            due;
        bit            to_b;
        logic [DW-1:0] data;
    } rsp_t;
    logic [DW-1:0] m_mem [DEPTH] = '{default: '0};
    rsp_t          m_pend [$];
    bit            m_favour_b = 1'b0;
    logic [AW-1:0] m_addr_hold = '0;
    logic [DW-1:0] m_din_hold  = '0;
    int            cyc = 0;

    logic          e_ga, e_gb, e_rva, e_rvb, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_dout;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic set_a(input logic v, input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        a_req_valid = v; a_req_wr = wr; a_req_addr = ad; a_req_din = d;
    endtask

    task automatic set_b(input logic v, input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        b_req_valid = v; b_req_wr = wr; b_req_addr = ad; b_req_din = d;
    endtask

    // Expected outputs for the current cycle from the current inputs.
    task automatic model_eval();
        e_ga = 1'b0; e_gb = 1'b0; e_rva = 1'b0; e_rvb = 1'b0; e_dout = '0;
        if (!rst) begin
            if (a_req_valid && (!b_req_valid || !m_favour_b)) e_ga = 1'b1;
            else if (b_req_valid) e_gb = 1'b1;
            if (m_pend.size() > 0 && m_pend[0].due == cyc) begin
                if (m_pend[0].to_b) e_rvb = 1'b1; else e_rva = 1'b1;
                e_dout = m_pend[0].data;
            end
        end
        e_wr   = e_ga ? a_req_wr   : (e_gb ? b_req_wr   : 1'b0);
        e_addr = e_ga ? a_req_addr : (e_gb ? b_req_addr : m_addr_hold);
        e_din  = e_ga ? a_req_din  : (e_gb ? b_req_din  : m_din_hold);
    endtask

    // Apply the cycle's effects: retire the response, perform the granted access.
    task automatic model_commit();
        if (m_pend.size() > 0 && m_pend[0].due == cyc) void'(m_pend.pop_front());
        if (rst) begin
            m_pend.delete();
            m_favour_b  = 1'b0;
            m_addr_hold = '0;
            m_din_hold  = '0;
        end else if (e_ga || e_gb) begin
            m_addr_hold = e_addr;
            m_din_hold  = e_din;
            if (e_wr) m_mem[e_addr] = e_din;
            else m_pend.push_back('{due: cyc + 2, to_b: e_gb, data: m_mem[e_addr]});
            m_favour_b = e_ga;
        end
        cyc++;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_a(1'b1, 1'b0, 8'h01, 8'h00);
        set_b(1'b1, 1'b0, 8'h02, 8'h00);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) rst = 1'b0;
            settle();
            n_cmp++;
            if ({a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, ram_wr_en} !== {e_ga, e_gb, e_rva, e_rvb, e_wr}) begin
                n_bad++;
                $display("FAIL reset_flags cyc %0d got %b want %b", cyc,
                         {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, ram_wr_en}, {e_ga, e_gb, e_rva, e_rvb, e_wr});
            end
            if (i == 3) begin
                n_cmp++;
                if ({a_req_ready, b_req_ready} !== 2'b10) begin
                    n_bad++;
                    $display("FAIL reset_first_grant got %b want 10", {a_req_ready, b_req_ready});
                end
            end
            advance();
        end
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        set_b(1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            settle();
            advance();
        end
    endtask

    task automatic test_single();
        int cnt_a = 0;
        int cnt_b = 0;
        for (int i = 0; i < 6; i++) begin
            case (i)
                1:       set_a(1'b1, 1'b1, 8'h10, 8'hA5);
                2:       set_a(1'b1, 1'b0, 8'h10, 8'h00);
                default: set_a(1'b0, 1'b0, 8'h00, 8'h00);
            endcase
            settle();
            cnt_a += int'(a_rsp_valid);
            cnt_b += int'(b_rsp_valid);
            n_cmp++;
            if ({a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, ram_wr_en} !== {e_ga, e_gb, e_rva, e_rvb, e_wr}) begin
                n_bad++;
                $display("FAIL single_flags cyc %0d got %b want %b", cyc,
                         {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, ram_wr_en}, {e_ga, e_gb, e_rva, e_rvb, e_wr});
            end
            n_cmp++;
            if ({ram_addr, ram_din} !== {e_addr, e_din}) begin
                n_bad++;
                $display("FAIL single_bus cyc %0d got %h want %h", cyc, {ram_addr, ram_din}, {e_addr, e_din});
            end
            if (i == 4) begin
                n_cmp++;
                if (a_rsp_valid !== 1'b1 || a_rsp_dout !== 8'hA5) begin
                    n_bad++;
                    $display("FAIL single_read_a5 got v=%b d=%h want v=1 d=a5", a_rsp_valid, a_rsp_dout);
                end
            end
            advance();
        end
        n_cmp++;
        if (cnt_a !== 1 || cnt_b !== 0) begin
            n_bad++;
            $display("FAIL single_rsp_count got a=%0d b=%0d want a=1 b=0", cnt_a, cnt_b);
        end
    endtask

    task automatic test_contention();
        logic [5:0] gs = '0;
        rst = 1'b1;
        settle();
        advance();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 6) begin
                set_a(1'b1, 1'b0, AW'($urandom_range(DEPTH - 1)), 8'h00);
                set_b(1'b1, 1'b0, AW'($urandom_range(DEPTH - 1)), 8'h00);
            end else begin
                set_a(1'b0, 1'b0, 8'h00, 8'h00);
                set_b(1'b0, 1'b0, 8'h00, 8'h00);
            end
            settle();
            if (i < 6) gs[5-i] = a_req_ready;
            n_cmp++;
            if ({a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, ram_wr_en} !== {e_ga, e_gb, e_rva, e_rvb, e_wr}) begin
                n_bad++;
                $display("FAIL contention_flags cyc %0d got %b want %b", cyc,
                         {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, ram_wr_en}, {e_ga, e_gb, e_rva, e_rvb, e_wr});
            end
            if (e_rva || e_rvb) begin
                n_cmp++;
                if ((e_rva ? a_rsp_dout : b_rsp_dout) !== e_dout) begin
                    n_bad++;
                    $display("FAIL contention_data cyc %0d got %h want %h", cyc, e_rva ? a_rsp_dout : b_rsp_dout, e_dout);
                end
            end
            advance();
        end
        n_cmp++;
        if (gs !== 6'b101010) begin
            n_bad++;
            $display("FAIL contention_order a-grant pattern got %b want 101010", gs);
        end
    endtask

    task automatic test_mixed();
        bit a_done = 1'b0;
        set_b(1'b0, 1'b0, 8'h00, 8'h00);
        set_a(1'b1, 1'b1, 8'h07, 8'h11);
        settle();
        advance();
        for (int i = 0; i < 10; i++) begin
            set_b(i < 7, 1'b0, 8'h07, 8'h00);
            if (i >= 2 && !a_done) set_a(1'b1, 1'b1, 8'h07, 8'h3C);
            else set_a(1'b0, 1'b0, 8'h00, 8'h00);
            settle();
            if (a_req_valid && a_req_ready) a_done = 1'b1;
            n_cmp++;
            if ({a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, ram_wr_en} !== {e_ga, e_gb, e_rva, e_rvb, e_wr}) begin
                n_bad++;
                $display("FAIL mixed_flags cyc %0d got %b want %b", cyc,
                         {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, ram_wr_en}, {e_ga, e_gb, e_rva, e_rvb, e_wr});
            end
            if (e_rvb) begin
                n_cmp++;
                if (b_rsp_dout !== e_dout) begin
                    n_bad++;
                    $display("FAIL mixed_data cyc %0d got %h want %h", cyc, b_rsp_dout, e_dout);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_read();
        int cnt = 0;
        for (int i = 0; i < 7; i++) begin
            rst = (i == 1);
            if (i == 0) set_a(1'b1, 1'b0, 8'h10, 8'h00);
            else if (i == 6) set_a(1'b1, 1'b0, 8'h10, 8'h00);
            else set_a(1'b0, 1'b0, 8'h00, 8'h00);
            set_b(i == 6, 1'b0, 8'h07, 8'h00);
            settle();
            if (i >= 1) cnt += int'(a_rsp_valid) + int'(b_rsp_valid);
            n_cmp++;
            if ({a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, ram_wr_en} !== {e_ga, e_gb, e_rva, e_rvb, e_wr}) begin
                n_bad++;
                $display("FAIL midrst_flags cyc %0d got %b want %b", cyc,
                         {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, ram_wr_en}, {e_ga, e_gb, e_rva, e_rvb, e_wr});
            end
            advance();
        end
        n_cmp++;
        if (cnt !== 0) begin
            n_bad++;
            $display("FAIL midrst_dropped got %0d responses want 0", cnt);
        end
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        set_b(1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            settle();
            advance();
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0:       set_a(1'b1, 1'b1, 8'hFF, 8'h5A);
                1:       set_a(1'b1, 1'b1, 8'h00, 8'hC3);
                2:       set_a(1'b1, 1'b0, 8'hFF, 8'h00);
                3:       set_a(1'b1, 1'b0, 8'h00, 8'h00);
                default: set_a(1'b0, 1'b0, 8'h00, 8'h00);
            endcase
            settle();
            n_cmp++;
            if ({a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, ram_wr_en} !== {e_ga, e_gb, e_rva, e_rvb, e_wr}) begin
                n_bad++;
                $display("FAIL wrap_flags cyc %0d got %b want %b", cyc,
                         {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, ram_wr_en}, {e_ga, e_gb, e_rva, e_rvb, e_wr});
            end
            if (e_rva) begin
                n_cmp++;
                if (a_rsp_dout !== e_dout) begin
                    n_bad++;
                    $display("FAIL wrap_data cyc %0d got %h want %h", cyc, a_rsp_dout, e_dout);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        bit acc_a = 1'b1;
        bit acc_b = 1'b1;
        for (int i = 0; i < 403; i++) begin
            if (i >= 400) begin
                set_a(1'b0, 1'b0, 8'h00, 8'h00);
                set_b(1'b0, 1'b0, 8'h00, 8'h00);
            end else begin
                if (acc_a || !a_req_valid)
                    set_a(1'($urandom_range(1)), 1'($urandom_range(1)), AW'($urandom_range(7)), DW'($urandom_range(255)));
                if (acc_b || !b_req_valid)
                    set_b(1'($urandom_range(1)), 1'($urandom_range(1)), AW'($urandom_range(7)), DW'($urandom_range(255)));
            end
            settle();
            acc_a = a_req_valid && a_req_ready;
            acc_b = b_req_valid && b_req_ready;
            n_cmp++;
            if ({a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, ram_wr_en} !== {e_ga, e_gb, e_rva, e_rvb, e_wr}) begin
                n_bad++;
                $display("FAIL random_flags cyc %0d got %b want %b", cyc,
                         {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, ram_wr_en}, {e_ga, e_gb, e_rva, e_rvb, e_wr});
            end
            n_cmp++;
            if ({ram_addr, ram_din} !== {e_addr, e_din}) begin
                n_bad++;
                $display("FAIL random_bus cyc %0d got %h want %h", cyc, {ram_addr, ram_din}, {e_addr, e_din});
            end
            if (e_rva || e_rvb) begin
                n_cmp++;
                if ((e_rva ? a_rsp_dout : b_rsp_dout) !== e_dout) begin
                    n_bad++;
                    $display("FAIL random_data cyc %0d got %h want %h", cyc, e_rva ? a_rsp_dout : b_rsp_dout, e_dout);
                end
            end
            advance();
        end
    endtask

    initial begin
        rst = 1'b1;
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        set_b(1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_contention();
        test_mixed();
        test_reset_mid_read();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
